// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: load-type encodings and datapath widths.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } load_type_e;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word extractor for loads: picks the addressed byte/halfword,
// sign- or zero-extends it, and reports misaligned word/halfword accesses.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        byte_off,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane gi holds the byte at address offset gi (offset 0 is the MSB).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = rdata[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    assign w_byte = w_bytes[byte_off];
    assign w_half = byte_off[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (load_type)
            LT_LH: begin
                data       = {{16{w_half[15]}}, w_half};
                misaligned = byte_off[0];
            end
            LT_LHU: begin
                data       = {16'd0, w_half};
                misaligned = byte_off[0];
            end
            LT_LB:  data = {{24{w_byte[7]}}, w_byte};
            LT_LBU: data = {24'd0, w_byte};
            default: begin
                data       = rdata;
                misaligned = (byte_off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, drives the register file write
// port, flags misaligned loads and counts retired instructions.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC_COUNT = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [2:0]            in_load_type,
    input  logic [1:0]            in_byte_off,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_rdata,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_align_err,
    output logic [31:0]           retire_count
);

    logic [DATA_W-1:0]     w_load_data;
    logic                  w_misaligned;
    logic                  w_bad_load;
    logic                  w_retire;

    logic                  r_valid;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_data;
    logic                  r_align_err;
    logic [31:0]           r_retire_count;

    load_align u_load_align (
        .rdata      (in_mem_rdata),
        .byte_off   (in_byte_off),
        .load_type  (in_load_type),
        .data       (w_load_data),
        .misaligned (w_misaligned)
    );

    // Alignment only matters when the load result is actually written back.
    assign w_bad_load = in_mem_to_reg & w_misaligned;
    assign w_retire   = in_valid & ~w_bad_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_addr         <= '0;
            r_data         <= '0;
            r_align_err    <= 1'b0;
            r_retire_count <= RESET_PC_COUNT;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_align_err <= 1'b0;
        end else if (!stall) begin
            r_valid     <= in_valid;
            r_reg_write <= in_valid & in_reg_write & (in_dest != '0) & ~w_bad_load;
            r_align_err <= in_valid & w_bad_load;
            // Bubbles present all-zero outputs, same as a flushed slot.
            r_addr      <= in_valid ? in_dest : '0;
            r_data      <= in_valid ? (in_mem_to_reg ? w_load_data : in_alu_result) : '0;
            if (w_retire)
                r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign wb_reg_write = r_reg_write & r_valid;
    assign wb_addr      = r_addr;
    assign wb_data      = r_data;
    assign wb_align_err = r_align_err;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid, in_reg_write, in_mem_to_reg;
    logic [2:0]  in_load_type;
    logic [1:0]  in_byte_off;
    logic [31:0] in_alu_result, in_mem_rdata;
    logic [4:0]  in_dest;

    logic        a_rw, b_rw, a_err, b_err;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data, a_cnt, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_rw, exp_err;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_cnt_a, exp_cnt_b;

    always #5 clk = ~clk;

    mem_wb_stage u_dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_load_type(in_load_type), .in_byte_off(in_byte_off),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_dest(in_dest),
        .wb_reg_write(a_rw), .wb_addr(a_addr), .wb_data(a_data),
        .wb_align_err(a_err), .retire_count(a_cnt)
    );

    mem_wb_stage #(.RESET_PC_COUNT(32'hFFFF_FFFF)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_load_type(in_load_type), .in_byte_off(in_byte_off),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_dest(in_dest),
        .wb_reg_write(b_rw), .wb_addr(b_addr), .wb_data(b_data),
        .wb_align_err(b_err), .retire_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: shift the big-endian word so the addressed unit lands in the LSBs.
    function automatic void model_load(input logic [2:0] lt, input logic [1:0] off,
                                       input logic [31:0] w,
                                       output logic [31:0] d, output logic mis);
        int          bo;
        logic [31:0] b, h;
        bo = int'(off);
        b  = (w >> (8 * (3 - bo))) & 32'h0000_00FF;
        h  = (w >> (16 * (1 - bo / 2))) & 32'h0000_FFFF;
        case (lt)
            3'd1: begin d = h[15] ? (h | 32'hFFFF_0000) : h; mis = (bo % 2) == 1; end
            3'd2: begin d = h;                               mis = (bo % 2) == 1; end
            3'd3: begin d = b[7] ? (b | 32'hFFFF_FF00) : b;  mis = 1'b0; end
            3'd4: begin d = b;                               mis = 1'b0; end
            default: begin d = w;                            mis = (bo != 0); end
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rw"},    {31'd0, a_rw},  {31'd0, exp_rw});
        check({tag, ".addr"},  {27'd0, a_addr}, {27'd0, exp_addr});
        if (!exp_err) check({tag, ".data"}, a_data, exp_data);
        check({tag, ".err"},   {31'd0, a_err}, {31'd0, exp_err});
        check({tag, ".cnt"},   a_cnt, exp_cnt_a);
        check({tag, ".b_rw"},  {31'd0, b_rw},  {31'd0, exp_rw});
        check({tag, ".b_err"}, {31'd0, b_err}, {31'd0, exp_err});
        check({tag, ".b_cnt"}, b_cnt, exp_cnt_b);
        $display("[TB] %s rw=%0b addr=%0d data=%08h err=%0b cnt=%08h/%08h",
                 tag, a_rw, a_addr, a_data, a_err, a_cnt, b_cnt);
    endtask

    // Advance one edge, update the model by the priority rules, then check.
    task automatic step(input string tag);
        logic [31:0] d;
        logic        mis, bad;
        model_load(in_load_type, in_byte_off, in_mem_rdata, d, mis);
        bad = in_mem_to_reg && mis;
        if (flush) begin
            exp_rw = 0; exp_err = 0; exp_addr = 0; exp_data = 0;
        end else if (!stall) begin
            exp_rw   = in_valid && in_reg_write && (in_dest != 0) && !bad;
            exp_err  = in_valid && bad;
            exp_addr = in_valid ? in_dest : 5'd0;
            exp_data = in_valid ? (in_mem_to_reg ? d : in_alu_result) : 32'd0;
            if (in_valid && !bad) begin
                exp_cnt_a = exp_cnt_a + 1;
                exp_cnt_b = exp_cnt_b + 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [1:0] off, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [4:0] dst);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
        in_byte_off = off; in_alu_result = alu; in_mem_rdata = rd; in_dest = dst;
    endtask

    task automatic model_reset();
        exp_rw = 0; exp_err = 0; exp_addr = 0; exp_data = 0;
        exp_cnt_a = 32'd0; exp_cnt_b = 32'hFFFF_FFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0;
        set_in(0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op; the preloaded instance wraps to 0 here.
        set_in(1, 1, 0, 3'd0, 2'd0, 32'h3066_3220, 32'd0, 5'd2);
        step("alu");
        check("alu.data_k", a_data, 32'h3066_3220);
        check("alu.cnt_k", a_cnt, 32'd1);
        check("wrap.cnt_k", b_cnt, 32'd0);

        set_in(1, 1, 1, 3'd3, 2'd0, 32'd0, 32'h80F1_7F02, 5'd5); step("lb0");
        check("lb0.k", a_data, 32'hFFFF_FF80);
        set_in(1, 1, 1, 3'd4, 2'd1, 32'd0, 32'h80F1_7F02, 5'd6); step("lbu1");
        check("lbu1.k", a_data, 32'h0000_00F1);
        set_in(1, 1, 1, 3'd1, 2'd2, 32'd0, 32'h80F1_7F02, 5'd7); step("lh2");
        check("lh2.k", a_data, 32'h0000_7F02);
        set_in(1, 1, 1, 3'd2, 2'd0, 32'd0, 32'h80F1_7F02, 5'd8); step("lhu0");
        check("lhu0.k", a_data, 32'h0000_80F1);

        set_in(1, 1, 1, 3'd0, 2'd2, 32'd0, 32'h1234_5678, 5'd9); step("lw_mis");
        check("lw_mis.err_k", {31'd0, a_err}, 32'd1);
        check("lw_mis.cnt_k", a_cnt, 32'd5);
        set_in(1, 1, 1, 3'd1, 2'd1, 32'd0, 32'h1234_5678, 5'd9); step("lh_mis");

        set_in(1, 1, 0, 3'd0, 2'd0, 32'hABC1_2345, 32'd0, 5'd0); step("dest0");
        check("dest0.cnt_k", a_cnt, 32'd6);

        set_in(1, 1, 0, 3'd0, 2'd0, 32'h0000_BEEF, 32'd0, 5'd12); step("pre_stall");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 3'd0, 2'd0, $urandom, 32'd0, 5'(i + 20));
            step("stall");
        end
        flush = 1; step("stall_flush");
        check("flush.data_k", a_data, 32'd0);
        stall = 0; flush = 0;

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 11) == 0);
            set_in($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
                   3'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom,
                   5'($urandom));
            step("rand");
        end
        stall = 0; flush = 0;

        // Asynchronous reset between edges while a write is in the WB slot.
        set_in(1, 1, 0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'd0, 5'd3);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 1, 0, 3'd0, 2'd0, 32'h0000_0042, 32'd0, 5'd4);
        step("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback formatter for the MIPS core. It captures the memory-stage result each cycle. It extracts and extends sub-word load data, selects between the ALU result and the load data, and drives the register file write port (`RegWrite`, `writeAddr`, `writeData` of `RegFile32x32`). It also flags misaligned loads and keeps a retired-instruction counter.

## Interface
- `RESET_PC_COUNT`, default 0: reset value of the retire counter.
- `clk`, in, 1: rising-edge clock, shared with the register file.
- `rst_n`, in, 1: asynchronous active-low reset.
- `stall`, in, 1: hold the pipeline register contents.
- `flush`, in, 1: load a bubble instead of the incoming instruction.
- `in_valid`, in, 1: the incoming instruction is real, not a bubble.
- `in_reg_write`, in, 1: the instruction writes a GPR.
- `in_mem_to_reg`, in, 1: 1 = write load data, 0 = write the ALU result.
- `in_load_type`, in, 3: LW=0, LH=1, LHU=2, LB=3, LBU=4; other codes are treated as LW.
- `in_byte_off`, in, 2: effective address bits [1:0].
- `in_alu_result`, in, 32: ALU result.
- `in_mem_rdata`, in, 32: raw aligned word read from data memory.
- `in_dest`, in, 5: destination register.
- `wb_reg_write`, out, 1: connects to the register file `RegWrite`.
- `wb_addr`, out, 5: connects to the register file `writeAddr`.
- `wb_data`, out, 32: connects to the register file `writeData`.
- `wb_align_err`, out, 1: misaligned load in the current WB slot.
- `retire_count`, out, 32: number of retired instructions.

## Operation
- Data memory is big-endian.
  - Byte offset 0 selects `rdata[31:24]`, offset 3 selects `[7:0]`.
  - Halfword offset 0 selects `[31:16]`, offset 2 selects `[15:0]`.
- Sign/zero extension:
  - LB and LH sign-extend to 32 bits.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Misaligned access:
  - LW with offset ≠ 0 is misaligned.
  - LH or LHU with offset bit 0 = 1 is misaligned.
  - Misalignment is checked only when `in_mem_to_reg` = 1.
- Write data is the extracted load data when `in_mem_to_reg` = 1, otherwise `in_alu_result`.
- `wb_reg_write` = valid & `in_reg_write` & (dest ≠ 0) & !misaligned. A write to $0 is never issued.
- `wb_align_err` = valid & `in_mem_to_reg` & misaligned. The write is suppressed in that case.
- Register update priority on each clock edge:
  - `flush` = 1: capture a bubble (valid = 0; all outputs 0). Flush wins over stall.
  - Else `stall` = 1: hold all registered state.
  - Else: capture the new inputs.
- `retire_count` increments by 1 on each edge that captures `in_valid` = 1 without a misalignment.
  - Writes to $0 and non-writing instructions do count.
  - A held (stalled) slot is never counted twice.
  - The counter wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, `rst_n` low) sets:
  - `wb_reg_write`, `wb_addr`, `wb_data` and `wb_align_err` to 0;
  - the internal valid bit to 0;
  - `retire_count` to `RESET_PC_COUNT`.
- Reset asserted mid-operation discards the slot immediately. No write is issued after reset is asserted.
- Latency from inputs to `wb_*` is 1 clock. The register file commits on the following edge, so a read of the register returns the new value 2 edges after the inputs are presented.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.
- During a stall, `wb_*` stay constant. The register file may rewrite the same value repeatedly; this is allowed and harmless.
- `wb_align_err` is high for exactly one cycle per misaligned load, or longer while that slot is stalled.

## Structure
- Shared package `mips_pkg` holds:
  - the load-type encodings (`LT_LW` … `LT_LBU`);
  - register-address width 5 and data width 32.
- The combinational extractor is a separate sub-module `load_align` with inputs `rdata`, `byte_off` and `load_type`, and outputs `data` and `misaligned`. It is instantiated once, before the pipeline register.
- The top level contains the pipeline register, the priority logic and the counter.

## Test plan
- Reset, then an ALU op: `in_alu_result`=0x30663220, dest=2, `reg_write`=1.
  - Required: one edge later `wb_addr`=2, `wb_data`=0x30663220, `wb_reg_write`=1; `retire_count`=1.
- Loads with `rdata`=0x80F1_7F02:
  - LB offset 0 → 0xFFFFFF80.
  - LBU offset 1 → 0x000000F1.
  - LH offset 2 → 0x00007F02.
  - LHU offset 0 → 0x000080F1.
- Misaligned loads:
  - LW offset 2 → `wb_align_err`=1, `wb_reg_write`=0, `retire_count` unchanged.
  - LH offset 1 → same response.
- Dest = 0 with `reg_write`=1 and data 0xABC12345 → `wb_reg_write`=0, `retire_count` still increments.
- Stall held for 3 cycles while the inputs change → `wb_*` frozen, `retire_count` +1 only.
- Stall and flush asserted together → bubble, all outputs 0.
- Assert `rst_n` low between clock edges during a valid write → outputs clear immediately, before the next edge.
- Preload the counter (`RESET_PC_COUNT`=0xFFFFFFFF) and retire one instruction → `retire_count`=0.
